// File: rtl/sd_rd_arbiter.sv
// Round-robin arbiter sharing one SD sector-read engine between two requesters.
// Splits each multi-sector request into per-sector start pulses and routes read data to the owner.
module sd_rd_arbiter #(
  parameter int SEC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [31:0]      req0_addr,
  input  logic [SEC_W-1:0] req0_num,
  input  logic             req1,
  input  logic [31:0]      req1_addr,
  input  logic [SEC_W-1:0] req1_num,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             val_en0,
  output logic             val_en1,
  output logic [15:0]      val_data,
  output logic             sd_rd_start,
  output logic [31:0]      sd_rd_addr,
  input  logic             sd_rd_busy,
  input  logic             sd_val_en,
  input  logic [15:0]      sd_val_data
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [SEC_W-1:0] SEC_ZERO = {SEC_W{1'b0}};
  localparam logic [SEC_W-1:0] SEC_ONE  = {{(SEC_W-1){1'b0}}, 1'b1};

  logic [1:0]       r_state;
  logic             r_busy_d0;
  logic             r_busy_d1;
  logic [31:0]      r_addr;
  logic [SEC_W-1:0] r_num;
  logic [SEC_W-1:0] r_cnt;
  logic             r_last;
  logic             r_gnt0;
  logic             r_gnt1;
  logic             r_done0;
  logic             r_done1;
  logic             r_start;
  logic [31:0]      r_sd_addr;
  logic             r_val_en0;
  logic             r_val_en1;
  logic [15:0]      r_val_data;

  logic             w_eos;
  logic             w_pick0;
  logic             w_pick1;
  logic             w_last_sec;
  logic [31:0]      w_sel_addr;
  logic [SEC_W-1:0] w_sel_num;

  // r_last == 1 means requester 1 was served last, so requester 0 wins a tie.
  assign w_eos      = r_busy_d1 & ~r_busy_d0;
  assign w_pick0    = req0 & (~req1 | r_last);
  assign w_pick1    = req1 & ~w_pick0;
  assign w_last_sec = (r_cnt == (r_num - SEC_ONE));
  assign w_sel_addr = w_pick0 ? req0_addr : req1_addr;
  assign w_sel_num  = w_pick0 ? req0_num  : req1_num;

  // Busy synchroniser whose falling edge marks the end of a sector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy_d0 <= 1'b0;
      r_busy_d1 <= 1'b0;
    end else begin
      r_busy_d0 <= sd_rd_busy;
      r_busy_d1 <= r_busy_d0;
    end
  end

  // Arbitration and per-sector sequencing FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_addr    <= 32'd0;
      r_num     <= SEC_ZERO;
      r_cnt     <= SEC_ZERO;
      r_last    <= 1'b1;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_done0   <= 1'b0;
      r_done1   <= 1'b0;
      r_start   <= 1'b0;
      r_sd_addr <= 32'd0;
    end else begin
      r_start <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pick0 || w_pick1) begin
            r_addr  <= w_sel_addr;
            r_num   <= w_sel_num;
            r_cnt   <= SEC_ZERO;
            r_gnt0  <= w_pick0;
            r_gnt1  <= w_pick1;
            // Zero-length requests complete without touching the engine.
            r_state <= (w_sel_num == SEC_ZERO) ? S_DONE : S_START;
          end else begin
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_START: begin
          r_start   <= 1'b1;
          r_sd_addr <= r_addr;
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          if (w_eos) begin
            r_cnt     <= r_cnt + SEC_ONE;
            r_sd_addr <= r_sd_addr + 32'd1;
            if (w_last_sec) begin
              r_state <= S_DONE;
            end else begin
              r_start <= 1'b1;
              r_state <= S_WAIT;
            end
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_DONE: begin
          r_done0 <= r_gnt0;
          r_done1 <= r_gnt1;
          r_last  <= r_gnt1;
          r_gnt0  <= 1'b0;
          r_gnt1  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_gnt0  <= 1'b0;
          r_gnt1  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Read data routed to the current owner; strobes with no owner are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_val_en0  <= 1'b0;
      r_val_en1  <= 1'b0;
      r_val_data <= 16'd0;
    end else begin
      r_val_en0  <= sd_val_en & r_gnt0;
      r_val_en1  <= sd_val_en & r_gnt1;
      r_val_data <= sd_val_data;
    end
  end

  assign gnt0        = r_gnt0;
  assign gnt1        = r_gnt1;
  assign done0       = r_done0;
  assign done1       = r_done1;
  assign val_en0     = r_val_en0;
  assign val_en1     = r_val_en1;
  assign val_data    = r_val_data;
  assign sd_rd_start = r_start;
  assign sd_rd_addr  = r_sd_addr;

endmodule

// File: tb/tb_sd_rd_arbiter.sv
// Directed self-checking bench for sd_rd_arbiter with a simple SD engine busy model.
module tb_sd_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [31:0] req0_addr = 32'd0, req1_addr = 32'd0;
  logic [15:0] req0_num = 16'd0, req1_num = 16'd0;
  logic        gnt0, gnt1, done0, done1, val_en0, val_en1;
  logic [15:0] val_data;
  logic        sd_rd_start;
  logic [31:0] sd_rd_addr;
  logic        sd_rd_busy;
  logic        sd_val_en = 1'b0;
  logic [15:0] sd_val_data = 16'd0;

  int chk_cnt = 0;
  int err_cnt = 0;

  sd_rd_arbiter #(.SEC_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req0_addr(req0_addr), .req0_num(req0_num),
    .req1(req1), .req1_addr(req1_addr), .req1_num(req1_num),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .val_en0(val_en0), .val_en1(val_en1), .val_data(val_data),
    .sd_rd_start(sd_rd_start), .sd_rd_addr(sd_rd_addr), .sd_rd_busy(sd_rd_busy),
    .sd_val_en(sd_val_en), .sd_val_data(sd_val_data)
  );

  always #10 clk = ~clk;

  // Engine model: busy for busy_len cycles after each start pulse.
  int busy_len = 10;
  int busy_cnt = 0;
  always @(posedge clk) begin
    if (sd_rd_start) busy_cnt <= busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign sd_rd_busy = (busy_cnt != 0);

  // Monitor: event counters sampled on the falling edge.
  int          st_cnt = 0, d0_cnt = 0, d1_cnt = 0, g1_seen = 0, overlap = 0, go_n = 0;
  logic [31:0] st_addr [0:63];
  int          go_ord  [0:15];
  logic        p_gnt0 = 1'b0, p_gnt1 = 1'b0;
  always @(negedge clk) begin
    if (sd_rd_start) begin st_addr[st_cnt % 64] = sd_rd_addr; st_cnt = st_cnt + 1; end
    if (done0) d0_cnt = d0_cnt + 1;
    if (done1) d1_cnt = d1_cnt + 1;
    if (gnt1) g1_seen = g1_seen + 1;
    if ((gnt0 && gnt1) || (done0 && done1)) overlap = overlap + 1;
    if (gnt0 && !p_gnt0 && go_n < 16) begin go_ord[go_n] = 0; go_n = go_n + 1; end
    if (gnt1 && !p_gnt1 && go_n < 16) begin go_ord[go_n] = 1; go_n = go_n + 1; end
    p_gnt0 = gnt0;
    p_gnt1 = gnt1;
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt = chk_cnt + 1;
    if (act !== exp) begin
      err_cnt = err_cnt + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    req0 = 1'b0; req1 = 1'b0; sd_val_en = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_gnt(input string tag, input int which, input int max_cyc);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      tick();
      ok = (which == 0) ? gnt0 : gnt1;
    end
    chk(tag, {63'd0, ok}, 64'd1);
  endtask

  task automatic wait_dones(input string tag, input int target, input int max_cyc);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      tick();
      ok = ((d0_cnt + d1_cnt) >= target);
    end
    chk(tag, {63'd0, ok}, 64'd1);
  endtask

  int s_base, d0_base, d1_base, g_base, g1_base;

  initial begin
    // Reset values.
    do_reset();
    chk("rst_ctl", {57'd0, gnt0, gnt1, done0, done1, val_en0, val_en1, sd_rd_start}, 64'd0);
    chk("rst_addr", {32'd0, sd_rd_addr}, 64'd0);
    chk("rst_data", {48'd0, val_data}, 64'd0);

    // Three-sector read for requester 0.
    s_base = st_cnt; d0_base = d0_cnt; g1_base = g1_seen;
    req0 = 1'b1; req0_addr = 32'd10496; req0_num = 16'd3;
    wait_gnt("r0_gnt", 0, 10);
    req0 = 1'b0;
    wait_dones("r0_done_wait", d0_base + d1_cnt + 1, 200);
    repeat (5) tick();
    chk("r0_starts", st_cnt - s_base, 64'd3);
    chk("r0_addr0", {32'd0, st_addr[s_base % 64]}, 64'd10496);
    chk("r0_addr1", {32'd0, st_addr[(s_base + 1) % 64]}, 64'd10497);
    chk("r0_addr2", {32'd0, st_addr[(s_base + 2) % 64]}, 64'd10498);
    chk("r0_done0", d0_cnt - d0_base, 64'd1);
    chk("r0_no_gnt1", g1_seen - g1_base, 64'd0);

    // Simultaneous requests alternate grants 0,1,0,1.
    do_reset();
    g_base = go_n; d0_base = d0_cnt; d1_base = d1_cnt;
    req0_addr = 32'd100; req0_num = 16'd1;
    req1_addr = 32'd200; req1_num = 16'd1;
    req0 = 1'b1; req1 = 1'b1;
    wait_dones("rr_done_wait", d0_base + d1_base + 4, 400);
    req0 = 1'b0; req1 = 1'b0;
    repeat (5) tick();
    chk("rr_g0", go_ord[g_base % 16], 64'd0);
    chk("rr_g1", go_ord[(g_base + 1) % 16], 64'd1);
    chk("rr_g2", go_ord[(g_base + 2) % 16], 64'd0);
    chk("rr_g3", go_ord[(g_base + 3) % 16], 64'd1);
    chk("rr_done0", d0_cnt - d0_base, 64'd2);
    chk("rr_done1", d1_cnt - d1_base, 64'd2);

    // Zero-length request from requester 1.
    s_base = st_cnt; d1_base = d1_cnt;
    req1 = 1'b1; req1_addr = 32'd55; req1_num = 16'd0;
    wait_gnt("z_gnt1", 1, 10);
    req1 = 1'b0;
    repeat (5) tick();
    chk("z_done1", d1_cnt - d1_base, 64'd1);
    chk("z_starts", st_cnt - s_base, 64'd0);

    // Data routing while requester 0 owns a long sector.
    busy_len = 600;
    d0_base = d0_cnt;
    req0 = 1'b1; req0_addr = 32'd7; req0_num = 16'd1;
    wait_gnt("dat_gnt0", 0, 10);
    req0 = 1'b0;
    for (int i = 0; i < 256; i++) begin
      sd_val_en = 1'b1;
      sd_val_data = 16'(i * 3 + 1);
      tick();
      chk("dat_beat", {46'd0, val_en1, val_en0, val_data}, {46'd0, 2'b01, 16'(i * 3 + 1)});
    end
    sd_val_en = 1'b0;
    tick();
    chk("dat_idle", {62'd0, val_en1, val_en0}, 64'd0);
    wait_dones("dat_done_wait", d0_base + d1_cnt + 1, 800);
    repeat (2) tick();
    for (int i = 0; i < 4; i++) begin
      sd_val_en = 1'b1;
      sd_val_data = 16'hA5A5;
      tick();
      chk("nogrant_drop", {62'd0, val_en1, val_en0}, 64'd0);
    end
    sd_val_en = 1'b0;
    busy_len = 10;
    repeat (700) tick();

    // Reset during sector 2 of 4 aborts silently.
    s_base = st_cnt;
    req0 = 1'b1; req0_addr = 32'd4000; req0_num = 16'd4;
    wait_gnt("abt_gnt0", 0, 10);
    req0 = 1'b0;
    for (int i = 0; i < 100 && (st_cnt - s_base) < 2; i++) tick();
    chk("abt_reached_s2", st_cnt - s_base, 64'd2);
    repeat (3) tick();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abt_ctl", {57'd0, gnt0, gnt1, done0, done1, val_en0, val_en1, sd_rd_start}, 64'd0);
    chk("abt_addr", {32'd0, sd_rd_addr}, 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    s_base = st_cnt; d0_base = d0_cnt; d1_base = d1_cnt;
    repeat (40) tick();
    chk("abt_no_start", st_cnt - s_base, 64'd0);
    chk("abt_no_done", (d0_cnt - d0_base) + (d1_cnt - d1_base), 64'd0);

    // Address wrap at 2^32.
    s_base = st_cnt; d0_base = d0_cnt;
    req0 = 1'b1; req0_addr = 32'hFFFF_FFFF; req0_num = 16'd2;
    wait_gnt("wrap_gnt0", 0, 10);
    req0 = 1'b0;
    wait_dones("wrap_done_wait", d0_base + d1_cnt + 1, 200);
    chk("wrap_starts", st_cnt - s_base, 64'd2);
    chk("wrap_a0", {32'd0, st_addr[s_base % 64]}, 64'hFFFF_FFFF);
    chk("wrap_a1", {32'd0, st_addr[(s_base + 1) % 64]}, 64'd0);

    chk("mutex", overlap, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
